// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg
// Shared types and constants for the LSU arbiter slice:
//   - arb_state_e : arbiter sequencing states
//   - master_id_e : which requester owns the access in flight
//   - F3_*        : RISC-V load/store size codes seen on funct3
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_LD = 2'd2
    } arb_state_e;

    typedef enum logic {
        MID_M0 = 1'b0,
        MID_M1 = 1'b1
    } master_id_e;

    // Loads
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    // Stores share the low codes with the signed loads
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

endpackage

// File: rtl/lsu_arb_align_chk.sv
// lsu_arb_align_chk
// Combinational alignment checker for one access.
// Ports:
//   i_funct3     in  3  size code of the access
//   i_addr_lo    in  2  low two address bits
//   o_misaligned out 1  1 = halfword on odd byte, or word not on a 4-byte boundary
// Only instantiated by lsu_arbiter when LSU_ARB_MISALIGN_CHK_EN is defined.
module lsu_arb_align_chk
    import lsu_arb_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    output logic       o_misaligned
);

    always_comb begin
        o_misaligned = 1'b0;
        case (i_funct3)
            F3_LH, F3_LHU: o_misaligned = i_addr_lo[0];
            F3_LW:         o_misaligned = |i_addr_lo;
            default:       o_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter
// Two-requester arbiter/sequencer in front of the single LSU port.
// M0 = pipeline data port, M1 = boot/debug loader. One access at a time;
// LSU strobes last exactly one cycle; load data returns LD_LATENCY cycles
// after the read strobe and is flagged by a one-cycle rvalid pulse.
// Parameters:
//   LD_LATENCY  cycles from read strobe to valid i_ld_data (1..3)
//   STARVE_MAX  consecutive M1 losses before M1 is forced to win
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_mX_req/we/addr/wdata/funct3      request from master X (held until gnt)
//   o_mX_gnt, o_mX_rvalid, o_mX_err    one-cycle pulses to master X
//   o_rdata                            last completed load data (shared)
//   o_lsu_wren/rden/addr, o_st_data,
//   o_funct3, i_ld_data                LSU port
// Optional feature: define LSU_ARB_MISALIGN_CHK_EN to reject misaligned
// halfword/word accesses with gnt+err instead of issuing them.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int LD_LATENCY = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_req,
    input  logic        i_m1_req,
    input  logic        i_m0_we,
    input  logic        i_m1_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [31:0] i_m1_wdata,
    input  logic [2:0]  i_m0_funct3,
    input  logic [2:0]  i_m1_funct3,
    output logic        o_m0_gnt,
    output logic        o_m1_gnt,
    output logic        o_m0_rvalid,
    output logic        o_m1_rvalid,
    output logic        o_m0_err,
    output logic        o_m1_err,
    output logic [31:0] o_rdata,
    output logic        o_lsu_wren,
    output logic        o_lsu_rden,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [2:0]  o_funct3,
    input  logic [31:0] i_ld_data
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [1:0]    LAT_LAST   = 2'(LD_LATENCY - 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [1:0]    lat_cnt_q, lat_cnt_d;
    master_id_e    id_q, id_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic          rv0_q, rv0_d, rv1_q, rv1_d;
    logic          wren_q, wren_d, rden_q, rden_d;
    logic [31:0]   lsu_addr_q, lsu_addr_d;
    logic [31:0]   st_data_q, st_data_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          win_m1, win_we, win_mis, arb_go;
    logic [31:0]   win_addr, win_wdata;
    logic [2:0]    win_f3;

    assign win_m1    = i_m1_req & (~i_m0_req | (starve_q == STARVE_LIM));
    assign win_we    = win_m1 ? i_m1_we     : i_m0_we;
    assign win_addr  = win_m1 ? i_m1_addr   : i_m0_addr;
    assign win_wdata = win_m1 ? i_m1_wdata  : i_m0_wdata;
    assign win_f3    = win_m1 ? i_m1_funct3 : i_m0_funct3;

    // A rejected request is answered while already back in IDLE; its master
    // still shows req that cycle, so arbitration sits out one cycle.
    assign arb_go = (state_q == IDLE) & (i_m0_req | i_m1_req) & ~(err0_q | err1_q);

`ifdef LSU_ARB_MISALIGN_CHK_EN
    lsu_arb_align_chk u_align_chk (
        .i_funct3     (win_f3),
        .i_addr_lo    (win_addr[1:0]),
        .o_misaligned (win_mis)
    );
    assign o_m0_err = err0_q;
    assign o_m1_err = err1_q;
`else
    assign win_mis  = 1'b0;
    assign o_m0_err = 1'b0;
    assign o_m1_err = 1'b0;
`endif

    // All outputs are registered: values computed here appear the cycle
    // after the decision, which is what places gnt/strobes in ISSUE.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        lat_cnt_d  = lat_cnt_q;
        id_d       = id_q;
        rdata_d    = rdata_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rv0_d      = 1'b0;
        rv1_d      = 1'b0;
        wren_d     = 1'b0;
        rden_d     = 1'b0;
        lsu_addr_d = '0;
        st_data_d  = '0;
        funct3_d   = '0;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    id_d   = win_m1 ? MID_M1 : MID_M0;
                    gnt0_d = ~win_m1;
                    gnt1_d = win_m1;
                    // A rejected M1 request still counts as M1 being served.
                    if (win_m1) begin
                        starve_d = '0;
                    end else if (i_m1_req && starve_q != STARVE_LIM) begin
                        starve_d = starve_q + SW'(1);
                    end
                    if (win_mis) begin
                        err0_d = ~win_m1;
                        err1_d = win_m1;
                    end else begin
                        wren_d     = win_we;
                        rden_d     = ~win_we;
                        lsu_addr_d = win_addr;
                        st_data_d  = win_wdata;
                        funct3_d   = win_f3;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                lat_cnt_d = '0;
                state_d   = rden_q ? WAIT_LD : IDLE;
            end
            WAIT_LD: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rdata_d = i_ld_data;
                    rv0_d   = (id_q == MID_M0);
                    rv1_d   = (id_q == MID_M1);
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            lat_cnt_q  <= '0;
            id_q       <= MID_M0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            lsu_addr_q <= '0;
            st_data_q  <= '0;
            funct3_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            lat_cnt_q  <= lat_cnt_d;
            id_q       <= id_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            lsu_addr_q <= lsu_addr_d;
            st_data_q  <= st_data_d;
            funct3_q   <= funct3_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_m0_gnt    = gnt0_q;
    assign o_m1_gnt    = gnt1_q;
    assign o_m0_rvalid = rv0_q;
    assign o_m1_rvalid = rv1_q;
    assign o_rdata     = rdata_q;
    assign o_lsu_wren  = wren_q;
    assign o_lsu_rden  = rden_q;
    assign o_lsu_addr  = lsu_addr_q;
    assign o_st_data   = st_data_q;
    assign o_funct3    = funct3_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter
// Self-checking bench for lsu_arbiter. A word-wide LSU stub with the
// configured read latency sits on the LSU port. A transaction-level model
// predicts, per arbitration decision, the cycle-exact gnt/err/strobe/rvalid
// schedule and the returned data; every cycle the DUT outputs are compared
// against that schedule. Directed tasks add explicit timing checks.
module tb_lsu_arbiter;

    localparam int LD_LATENCY = 1;
    localparam int STARVE_MAX = 8;
    localparam int RING       = 64;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_m0_req, i_m1_req, i_m0_we, i_m1_we;
    logic [31:0] i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata;
    logic [2:0]  i_m0_funct3, i_m1_funct3;
    logic        o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err;
    logic [31:0] o_rdata, o_lsu_addr, o_st_data, i_ld_data;
    logic        o_lsu_wren, o_lsu_rden;
    logic [2:0]  o_funct3;

    lsu_arbiter #(.LD_LATENCY(LD_LATENCY), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_req(i_m0_req), .i_m1_req(i_m1_req),
        .i_m0_we(i_m0_we), .i_m1_we(i_m1_we),
        .i_m0_addr(i_m0_addr), .i_m1_addr(i_m1_addr),
        .i_m0_wdata(i_m0_wdata), .i_m1_wdata(i_m1_wdata),
        .i_m0_funct3(i_m0_funct3), .i_m1_funct3(i_m1_funct3),
        .o_m0_gnt(o_m0_gnt), .o_m1_gnt(o_m1_gnt),
        .o_m0_rvalid(o_m0_rvalid), .o_m1_rvalid(o_m1_rvalid),
        .o_m0_err(o_m0_err), .o_m1_err(o_m1_err),
        .o_rdata(o_rdata),
        .o_lsu_wren(o_lsu_wren), .o_lsu_rden(o_lsu_rden),
        .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data),
        .o_funct3(o_funct3), .i_ld_data(i_ld_data)
    );

    always #5 i_clk = ~i_clk;

    // LSU stub: 64 words, read data appears LD_LATENCY cycles after rden.
    logic [31:0] stub_mem [0:63];
    logic [31:0] ld_pipe  [0:LD_LATENCY-1];
    always @(posedge i_clk) begin
        if (o_lsu_wren) stub_mem[o_lsu_addr[7:2]] <= o_st_data;
        ld_pipe[0] <= o_lsu_rden ? stub_mem[o_lsu_addr[7:2]] : 32'hDEAD_BEEF;
        for (int i = 1; i < LD_LATENCY; i++) ld_pipe[i] <= ld_pipe[i-1];
    end
    assign i_ld_data = ld_pipe[LD_LATENCY-1];

    typedef struct packed {
        logic        gnt0, gnt1, err0, err1, rv0, rv1, wren, rden;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
    } obs_t;

    // Reference model state
    obs_t        sched [0:RING-1];
    logic [31:0] mem_model [0:63];
    logic [31:0] m_rdata;
    int          starve, next_free, cyc;

    // Scoreboard counters and observation log
    int vectors, miscompares;
    int g0_cyc, g1_cyc, rv0_cyc, rv1_cyc, e1_cyc, wr_cyc, rd_cyc;
    int g0_n, g1_n, rv0_n, rv1_n, e1_n, wr_n, rd_n;
    logic [31:0] wr_addr, wr_data, rd_addr;

    task automatic clear_model();
        for (int i = 0; i < RING; i++) sched[i] = '0;
        m_rdata = '0;
        starve  = 0;
    endtask

    task automatic set_req(input int m, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        if (m == 0) begin
            i_m0_req = 1'b1; i_m0_we = we; i_m0_addr = a; i_m0_wdata = d; i_m0_funct3 = f;
        end else begin
            i_m1_req = 1'b1; i_m1_we = we; i_m1_addr = a; i_m1_wdata = d; i_m1_funct3 = f;
        end
    endtask

    // Advance one cycle, compare all outputs to the model schedule, log pulses,
    // and drop the request of any master that was granted.
    task automatic tick();
        obs_t exp_o, act_o;
        int   slot;
        @(posedge i_clk); #1;
        cyc++;
        slot = cyc % RING;
        exp_o = sched[slot];
        sched[slot] = '0;
        if (exp_o.rv0 || exp_o.rv1) m_rdata = exp_o.rdata;
        exp_o.rdata = m_rdata;
        act_o = {o_m0_gnt, o_m1_gnt, o_m0_err, o_m1_err, o_m0_rvalid, o_m1_rvalid,
                 o_lsu_wren, o_lsu_rden, o_lsu_addr, o_st_data, o_funct3, o_rdata};
        vectors++;
        if (act_o !== exp_o) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_o, exp_o);
        end
        if (o_m0_gnt)    begin g0_cyc = cyc; g0_n++; i_m0_req = 1'b0; end
        if (o_m1_gnt)    begin g1_cyc = cyc; g1_n++; i_m1_req = 1'b0; end
        if (o_m0_rvalid) begin rv0_cyc = cyc; rv0_n++; end
        if (o_m1_rvalid) begin rv1_cyc = cyc; rv1_n++; end
        if (o_m1_err)    begin e1_cyc = cyc; e1_n++; end
        if (o_lsu_wren)  begin wr_cyc = cyc; wr_n++; wr_addr = o_lsu_addr; wr_data = o_st_data; end
        if (o_lsu_rden)  begin rd_cyc = cyc; rd_n++; rd_addr = o_lsu_addr; end
    endtask

    // Model one arbitration on the inputs presented in the current cycle.
    task automatic decide();
        logic w1, we, mis;
        logic [31:0] a, d;
        logic [2:0]  f;
        int s1, s2;
        if (cyc < next_free || !(i_m0_req || i_m1_req)) return;
        w1 = i_m1_req && (!i_m0_req || starve == STARVE_MAX);
        we = w1 ? i_m1_we     : i_m0_we;
        a  = w1 ? i_m1_addr   : i_m0_addr;
        d  = w1 ? i_m1_wdata  : i_m0_wdata;
        f  = w1 ? i_m1_funct3 : i_m0_funct3;
        if (w1) starve = 0;
        else if (i_m1_req && starve < STARVE_MAX) starve++;
`ifdef LSU_ARB_MISALIGN_CHK_EN
        mis = ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        s1 = (cyc + 1) % RING;
        if (w1) sched[s1].gnt1 = 1'b1; else sched[s1].gnt0 = 1'b1;
        if (mis) begin
            if (w1) sched[s1].err1 = 1'b1; else sched[s1].err0 = 1'b1;
            next_free = cyc + 2;
        end else begin
            sched[s1].wren  = we;
            sched[s1].rden  = !we;
            sched[s1].addr  = a;
            sched[s1].sdata = d;
            sched[s1].f3    = f;
            if (we) begin
                mem_model[a[7:2]] = d;
                next_free = cyc + 2;
            end else begin
                s2 = (cyc + 2 + LD_LATENCY) % RING;
                if (w1) sched[s2].rv1 = 1'b1; else sched[s2].rv0 = 1'b1;
                sched[s2].rdata = mem_model[a[7:2]];
                next_free = cyc + 2 + LD_LATENCY;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        cyc++;
        vectors++;
        if ({o_m0_gnt, o_m1_gnt, o_m0_err, o_m1_err, o_m0_rvalid, o_m1_rvalid, o_lsu_wren,
             o_lsu_rden, o_lsu_addr, o_st_data, o_funct3, o_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: outputs not all zero (rdata=%h addr=%h)", o_rdata, o_lsu_addr);
        end
        i_rst_n   = 1'b1;
        clear_model();
        next_free = cyc;
        repeat (2) begin tick(); decide(); end
    endtask

    task automatic test_store_load();
        int t;
        int wn;
        set_req(0, 1'b1, 32'h3000, 32'h1234_5678, 3'd2);
        t  = cyc;
        wn = wr_n;
        decide();
        repeat (5) begin tick(); decide(); end
        vectors++;
        if (g0_cyc != t + 1 || wr_cyc != t + 1) begin
            miscompares++;
            $display("FAIL store_timing: gnt at %0d wren at %0d, required %0d", g0_cyc, wr_cyc, t + 1);
        end
        vectors++;
        if (wr_n != wn + 1 || wr_addr !== 32'h3000 || wr_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL store_values: %0d strobes addr %h data %h, required 1/00003000/12345678",
                     wr_n - wn, wr_addr, wr_data);
        end
        set_req(0, 1'b0, 32'h3000, 32'h0, 3'd2);
        t = cyc;
        decide();
        repeat (6) begin tick(); decide(); end
        vectors++;
        if (rv0_cyc != t + 2 + LD_LATENCY || o_rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL readback: rvalid at %0d rdata %h, required %0d 12345678",
                     rv0_cyc, o_rdata, t + 2 + LD_LATENCY);
        end
    endtask

    task automatic test_reset_midload();
        int rvb;
        set_req(0, 1'b0, 32'h3000, 32'h0, 3'd2);
        decide();
        tick(); decide();   // ISSUE
        tick();             // WAIT_LD
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_lsu_wren, o_lsu_rden,
             o_lsu_addr, o_st_data, o_funct3, o_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_midload_async: outputs not zero, rdata %h required 0", o_rdata);
        end
        clear_model();
        rvb = rv0_n;
        @(posedge i_clk); #1;
        cyc++;
        i_rst_n   = 1'b1;
        next_free = cyc;
        repeat (6) begin tick(); decide(); end
        vectors++;
        if (rv0_n != rvb) begin
            miscompares++;
            $display("FAIL reset_midload_rvalid: %0d rvalid pulses after reset, required 0", rv0_n - rvb);
        end
    endtask

    task automatic test_starve();
        int b0, b1;
        b0 = g0_n;
        b1 = g1_n;
        set_req(0, 1'b1, 32'h3010, $urandom, 3'd2);
        set_req(1, 1'b1, 32'h3020, 32'hA5A5_0001, 3'd2);
        decide();
        for (int i = 0; i < 60 && g1_n == b1; i++) begin
            tick();
            if (!i_m0_req) set_req(0, 1'b1, 32'h3010, $urandom, 3'd2);
            decide();
        end
        vectors++;
        if (g1_n != b1 + 1 || g0_n - b0 != STARVE_MAX) begin
            miscompares++;
            $display("FAIL starve_count: M0 wins before M1 %0d (M1 gnts %0d), required %0d (1)",
                     g0_n - b0, g1_n - b1, STARVE_MAX);
        end
        set_req(1, 1'b1, 32'h3024, 32'hA5A5_0002, 3'd2);
        decide();
        b0 = g0_n;
        b1 = g1_n;
        for (int i = 0; i < 10 && g0_n == b0 && g1_n == b1; i++) begin
            tick(); decide();
        end
        vectors++;
        if (g0_n != b0 + 1 || g1_n != b1) begin
            miscompares++;
            $display("FAIL starve_resume: next winner M0=%0d M1=%0d, required M0=1 M1=0",
                     g0_n - b0, g1_n - b1);
        end
        repeat (20) begin tick(); decide(); end
    endtask

    task automatic rand_req(input int m);
        logic        we;
        logic [2:0]  f;
        logic [31:0] a;
        we = 1'($urandom_range(0, 1));
        a  = 32'h3000 + 32'($urandom_range(0, 15)) * 32'd4;
        if (we) f = 3'($urandom_range(0, 2));
        else begin
            f = 3'($urandom_range(0, 4));
            if (f == 3'd3) f = 3'd5;
        end
        set_req(m, we, a, $urandom, f);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (!i_m0_req && $urandom_range(0, 2) == 0) rand_req(0);
            if (!i_m1_req && $urandom_range(0, 2) == 0) rand_req(1);
            decide();
        end
        repeat (30) begin tick(); decide(); end
    endtask

    task automatic test_misalign();
        int t, sn, en;
        sn = wr_n + rd_n;
        en = e1_n;
        set_req(1, 1'b0, 32'h3001, 32'h0, 3'd1);
        t = cyc;
        decide();
        repeat (6) begin tick(); decide(); end
`ifdef LSU_ARB_MISALIGN_CHK_EN
        vectors++;
        if (g1_cyc != t + 1 || e1_cyc != t + 1 || e1_n != en + 1 || wr_n + rd_n != sn) begin
            miscompares++;
            $display("FAIL misalign_reject: gnt %0d err %0d strobes %0d, required gnt=err=%0d strobes 0",
                     g1_cyc, e1_cyc, wr_n + rd_n - sn, t + 1);
        end
        set_req(1, 1'b0, 32'h3002, 32'h0, 3'd1);
        t = cyc;
        decide();
        repeat (6) begin tick(); decide(); end
        vectors++;
        if (g1_cyc != t + 1 || rd_cyc != t + 1 || rd_addr !== 32'h3002 || e1_n != en + 1
            || rv1_cyc != t + 2 + LD_LATENCY) begin
            miscompares++;
            $display("FAIL misalign_aligned_follow: gnt %0d rden %0d addr %h rvalid %0d, required %0d %0d 00003002 %0d",
                     g1_cyc, rd_cyc, rd_addr, rv1_cyc, t + 1, t + 1, t + 2 + LD_LATENCY);
        end
`else
        vectors++;
        if (g1_cyc != t + 1 || rd_cyc != t + 1 || rd_addr !== 32'h3001 || e1_n != en) begin
            miscompares++;
            $display("FAIL unchecked_passthrough: gnt %0d rden %0d addr %h errs %0d, required %0d %0d 00003001 0",
                     g1_cyc, rd_cyc, rd_addr, e1_n - en, t + 1, t + 1);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; next_free = 0;
        g0_cyc = -1; g1_cyc = -1; rv0_cyc = -1; rv1_cyc = -1; e1_cyc = -1; wr_cyc = -1; rd_cyc = -1;
        g0_n = 0; g1_n = 0; rv0_n = 0; rv1_n = 0; e1_n = 0; wr_n = 0; rd_n = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int i = 0; i < 64; i++) begin
            stub_mem[i]  = '0;
            mem_model[i] = '0;
        end
        for (int i = 0; i < LD_LATENCY; i++) ld_pipe[i] = '0;
        i_m0_req = 1'b0; i_m1_req = 1'b0; i_m0_we = 1'b0; i_m1_we = 1'b0;
        i_m0_addr = '0; i_m1_addr = '0; i_m0_wdata = '0; i_m1_wdata = '0;
        i_m0_funct3 = '0; i_m1_funct3 = '0;
        clear_model();

        test_reset();
        test_store_load();
        test_reset_midload();
        test_starve();
        test_misalign();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-requester arbiter and sequencer in front of the single LSU port in the MA stage. It shares the LSU, with its data memory and memory-mapped IO (LEDR/LEDG/HEX/LCD outputs, SW/BTN inputs), between the pipeline data port (M0) and the boot/debug loader (M1). It serialises accesses and drives the LSU strobes for exactly one cycle per access. It returns load data with a valid pulse after a fixed LSU read latency.

## Interface
Parameters:
- LD_LATENCY, 1: cycles from LSU read strobe to valid `i_ld_data` (legal 1..3).
- STARVE_MAX, 8: consecutive cycles M1 may wait while M0 wins before M1 is forced to win.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_m0_req, i_m1_req  in  1  access request; held with fields stable until `o_mX_gnt`.
- i_m0_we, i_m1_we  in  1  1 = store, 0 = load.
- i_m0_addr, i_m1_addr  in  32  byte address.
- i_m0_wdata, i_m1_wdata  in  32  store data.
- i_m0_funct3, i_m1_funct3  in  3  RISC-V load/store size code.
- o_m0_gnt, o_m1_gnt  out  1  one-cycle pulse: request accepted and issued.
- o_m0_rvalid, o_m1_rvalid  out  1  one-cycle pulse: `o_rdata` valid for that master.
- o_m0_err, o_m1_err  out  1  one-cycle pulse: request rejected. Only active with the alignment macro.
- o_rdata  out  32  load data, shared by both masters.
- o_lsu_wren, o_lsu_rden  out  1  LSU strobes.
- o_lsu_addr, o_st_data  out  32  LSU address and store data.
- o_funct3  out  3  LSU size code.
- i_ld_data  in  32  LSU load result.

## Operation
- FSM states: IDLE, ISSUE, WAIT_LD.
- IDLE:
  - If any request is present, select a winner and latch its we/addr/wdata/funct3 and id, then go to ISSUE.
  - Selection: M0 wins unless the starve counter equals STARVE_MAX, in which case M1 wins.
- ISSUE (exactly one cycle):
  - Drive `o_lsu_*` from the latched request.
  - Assert `o_lsu_wren` for a store or `o_lsu_rden` for a load.
  - Pulse the winner's `o_gnt`.
  - Store: go to IDLE. Load: go to WAIT_LD.
- WAIT_LD: count LD_LATENCY cycles. On the final count:
  - capture `i_ld_data` into `o_rdata`;
  - pulse the winner's `o_rvalid` in the next cycle;
  - go to IDLE.
- Starve counter, width $clog2(STARVE_MAX+1):
  - increments in each IDLE cycle where M1 requests and loses;
  - saturates at STARVE_MAX;
  - clears when M1 is granted.
- Outside ISSUE, all `o_lsu_*` outputs are 0. The strobes are never both high.
- `o_rdata` holds its last value until the next load completes.

## Timing
- Reset: state IDLE, starve counter 0, every output 0. No rvalid is ever emitted for a load aborted by reset.
- Store: request seen in IDLE at cycle N; ISSUE, gnt and wren at N+1; the next decision can occur at N+2.
- Load: ISSUE at N+1; rvalid at N+2+LD_LATENCY.
- Simultaneous requests: M0 wins; M1 waits, and its counter increments.
- A request raised during ISSUE or WAIT_LD is sampled at the next IDLE cycle.
- Dropping req before gnt violates the protocol. If req drops after latching, the access still completes.

## Configuration
- Macro `LSU_ARB_MISALIGN_CHK_EN`.
- Defined: in IDLE, check the winner's alignment:
  - halfword (funct3 1/5) requires addr[0]=0;
  - word (funct3 2) requires addr[1:0]=0.
- A misaligned request:
  - skips ISSUE entirely, so no LSU strobe is driven;
  - pulses `o_err` and `o_gnt` together one cycle later;
  - returns to IDLE.
- Starve accounting treats a misaligned M1 request as a grant.
- Undefined: `o_m0_err` and `o_m1_err` are tied to 0, and all accesses pass through unchecked.

## Structure
- Package `lsu_arb_pkg` contains:
  - the FSM state enum;
  - funct3 constants LB=0, LH=1, LW=2, LBU=4, LHU=5 (SB/SH/SW share 0/1/2);
  - the master-id type.
- Sub-module `lsu_arb_align_chk` is a combinational checker on funct3 and addr. It is instantiated only when the macro is defined.

## Test plan
- Reset mid-load:
  - Stimulus: M0 load 0x3000, then assert `i_rst_n`=0 in WAIT_LD.
  - Response: all outputs 0 immediately; no rvalid after release.
- Single store:
  - Stimulus: M0 SW addr 0x3000, data 0x12345678.
  - Response: wren high for exactly one cycle with those values; gnt in the same cycle.
- Read-back:
  - Stimulus: M0 LW 0x3000 after the store above, LD_LATENCY=1.
  - Response: rvalid 3 cycles after the request cycle; `o_rdata`=0x12345678.
- Starvation (STARVE_MAX=8):
  - Stimulus: M0 and M1 request continuously.
  - Response: M1 is granted at its 9th arbitration, then M0 resumes winning.
- Misalignment (macro on):
  - Stimulus: M1 LH 0x3001.
  - Response: err and gnt pulse together; no LSU strobe. A following M1 LH 0x3002 issues normally.
